// File: rtl/alu_pkg.sv
// Shared opcode/dtype constants and FSM state encoding for alu_multicycle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_DIV = 5'h08;

  localparam logic [3:0] DT_UNS = 4'h1;
  localparam logic [3:0] DT_SGN = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic dtype_ok(input logic [3:0] dt);
    return (dt == DT_UNS) || (dt == DT_SGN);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between a requester and alu_multicycle.
// Latency: n/a (wires only).
// Backpressure: requester must watch busy; start is ignored while busy.
interface alu_multicycle_if #(parameter int W = 16);
  logic           start;
  logic [3:0]     dtype;
  logic [4:0]     op;
  logic [W-1:0]   src1;
  logic [W-1:0]   src2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           err;
  logic           dz;

  modport master (
    output start, dtype, op, src1, src2,
    input  busy, done, result, err, dz
  );

  modport slave (
    input  start, dtype, op, src1, src2,
    output busy, done, result, err, dz
  );
endinterface

// File: rtl/alu_iter_core.sv
// Iterative magnitude datapath: shift-add multiply, restoring divide (ALU_MULTICYCLE_DIV_EN).
// Latency: exactly W step cycles after load; last is high on the final step cycle.
// Backpressure: none; the FSM owns load/step and never stalls mid-iteration.
module alu_iter_core #(parameter int W = 16) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res,
  output logic           last
);

  localparam int CW = $clog2(W);

  // hi:lo is the product (mul) or remainder:quotient (div); mcand is multiplicand/divisor
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo, mcand;
  logic [W-1:0]  hi_nxt, lo_nxt;
  logic [W:0]    mul_sum;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
`else
  logic          unused_is_div;
  assign unused_is_div = is_div;
`endif

  // one shift-add (mul) or shift-subtract-restore (div) step
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    hi_nxt  = mul_sum[W:1];
    lo_nxt  = {mul_sum[0], lo[W-1:1]};
`ifdef ALU_MULTICYCLE_DIV_EN
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (is_div) begin
      // remainder stays below the divisor, so a clear borrow bit means "fits"
      if (!div_diff[W]) begin
        hi_nxt = div_diff[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b0};
      end
    end
`endif
  end

  // operands load on accept, then one step per ITER cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      mcand <= b;
      cnt   <= '0;
    end else if (step) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(W - 1));
  assign res  = {hi, lo};

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU (add/sub/mul, div when ALU_MULTICYCLE_DIV_EN is defined), W-bit operands, 2W result.
// Latency: add/sub/illegal done 1 cycle after accept; mul/div done W+2 cycles after accept.
// Backpressure: one request at a time; start is only sampled in IDLE (busy low).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_multicycle_if.slave  bus
);

  state_t         state, state_nxt;
  logic           accept, legal, is_iter, iter_last, sgn;
  logic [2*W-1:0] ext1, ext2, addsub;
  logic [W-1:0]   mag1, mag2;
  logic [2*W-1:0] core_res, fix_val, result_q;
  logic           err_q;
  logic           l_neg;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic           l_div, l_rneg, l_dz, dz_q;
  logic [W-1:0]   l_src1, quot, rem;
`endif

  assign accept = (state == ST_IDLE) && bus.start;
  assign sgn    = (bus.dtype == DT_SGN);

  // request decode: which ops take the iterative path, and whether the request is legal
  always_comb begin
    is_iter = (bus.op == OP_MUL);
`ifdef ALU_MULTICYCLE_DIV_EN
    is_iter = is_iter || (bus.op == OP_DIV);
`endif
    legal = dtype_ok(bus.dtype) && ((bus.op == OP_ADD) || (bus.op == OP_SUB) || is_iter);
  end

  // single-cycle add/sub on extended operands, plus magnitudes for the iterative core
  always_comb begin
    ext1   = sgn ? {{W{bus.src1[W-1]}}, bus.src1} : {{W{1'b0}}, bus.src1};
    ext2   = sgn ? {{W{bus.src2[W-1]}}, bus.src2} : {{W{1'b0}}, bus.src2};
    addsub = (bus.op == OP_SUB) ? (ext1 - ext2) : (ext1 + ext2);
    mag1   = (sgn && bus.src1[W-1]) ? -bus.src1 : bus.src1;
    mag2   = (sgn && bus.src2[W-1]) ? -bus.src2 : bus.src2;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: add/sub/illegal go straight to DONE, mul/div iterate W cycles then fix signs
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = (legal && is_iter) ? ST_ITER : ST_DONE;
      ST_ITER: if (iter_last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // sign/divide bookkeeping captured at accept for the FIX stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_neg  <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
      l_div  <= 1'b0;
      l_rneg <= 1'b0;
      l_dz   <= 1'b0;
      l_src1 <= '0;
`endif
    end else if (accept) begin
      l_neg  <= sgn && (bus.src1[W-1] ^ bus.src2[W-1]);
`ifdef ALU_MULTICYCLE_DIV_EN
      l_div  <= (bus.op == OP_DIV);
      l_rneg <= sgn && bus.src1[W-1];
      l_dz   <= (bus.src2 == '0);
      l_src1 <= bus.src1;
`endif
    end
  end

  alu_iter_core #(.W(W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && legal && is_iter),
    .step   (state == ST_ITER),
`ifdef ALU_MULTICYCLE_DIV_EN
    .is_div (l_div),
`else
    .is_div (1'b0),
`endif
    .a      (mag1),
    .b      (mag2),
    .res    (core_res),
    .last   (iter_last)
  );

  // FIX stage: reapply signs to the magnitude result; divide-by-zero overrides the divider output
  always_comb begin
    fix_val = l_neg ? -core_res : core_res;
`ifdef ALU_MULTICYCLE_DIV_EN
    quot = core_res[W-1:0];
    rem  = core_res[2*W-1:W];
    if (l_div) begin
      if (l_dz) fix_val = {{W{1'b1}}, l_src1};
      else      fix_val = {(l_neg ? -quot : quot), (l_rneg ? -rem : rem)};
    end
`endif
  end

  // result/err: cleared or loaded at accept, iterative results land on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      err_q <= !legal;
      if (!legal)        result_q <= '0;
      else if (!is_iter) result_q <= addsub;
    end else if (state == ST_FIX) begin
      result_q <= fix_val;
    end
  end

`ifdef ALU_MULTICYCLE_DIV_EN
  // dz: cleared at accept, raised alongside a divide-by-zero result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  dz_q <= 1'b0;
    else if (accept)          dz_q <= 1'b0;
    else if (state == ST_FIX) dz_q <= l_div && l_dz;
  end
  assign bus.dz = dz_q;
`else
  assign bus.dz = 1'b0;
`endif

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed bench for alu_multicycle against an arithmetic reference model.
// Latency: checks done timing per transaction (1 or W+2 cycles after accept).
// Backpressure: issues the next request in the first IDLE cycle after done.
module tb_alu_multicycle;

  localparam int W = 16;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2*W-1:0] prev_res;
  logic [2*W-1:0] last_res;
  logic           last_err;
  logic           last_dz;
  logic [4:0]     op_tab [6];

  alu_multicycle_if #(.W(W)) bus ();

  alu_multicycle #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operands as the dtype interprets them
  function automatic void model(input logic [3:0] dt, input logic [4:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2*W-1:0] r, output logic e,
                                output logic z, output int lat);
    longint va, vb, q, m;
    bit legal;
    legal = ((dt == 4'h1) || (dt == 4'h2)) &&
            ((op == 5'h01) || (op == 5'h02) || (op == 5'h04) || (DIV_EN && (op == 5'h08)));
    va  = (dt == 4'h2) ? longint'($signed(a)) : longint'(a);
    vb  = (dt == 4'h2) ? longint'($signed(b)) : longint'(b);
    r   = '0;
    e   = !legal;
    z   = 1'b0;
    lat = 1;
    if (legal) begin
      case (op)
        5'h01: r = (2*W)'(va + vb);
        5'h02: r = (2*W)'(va - vb);
        5'h04: begin r = (2*W)'(va * vb); lat = W + 2; end
        default: begin
          lat = W + 2;
          if (vb == 0) begin
            z = 1'b1;
            r = {{W{1'b1}}, a};
          end else begin
            q = va / vb;
            m = va % vb;
            r = {q[W-1:0], m[W-1:0]};
          end
        end
      endcase
    end
  endfunction

  task automatic issue(input logic [3:0] dt, input logic [4:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.dtype = dt;
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.start = 1'b1;
    @(posedge clk);
  endtask

  // called right after the accepting edge; waits (bounded) for done and checks everything
  task automatic collect(input string tag, input logic [3:0] dt, input logic [4:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    logic [2*W-1:0] er;
    logic ee, ez;
    int elat, lat;
    bit seen;
    model(dt, op, a, b, er, ee, ez, elat);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4*W) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, bus.busy, 1);
        if (elat > 1) check({tag, "_hold"}, bus.result, prev_res);
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, bus.result, er);
    check({tag, "_err"}, bus.err, ee);
    check({tag, "_dz"}, bus.dz, ez);
    last_res = bus.result;
    last_err = bus.err;
    last_dz  = bus.dz;
    prev_res = er;
  endtask

  task automatic run(input string tag, input logic [3:0] dt, input logic [4:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    issue(dt, op, a, b);
    collect(tag, dt, op, a, b, 1'b0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int extra;
    logic [3:0] dt;
    logic [4:0] op;
    logic [W-1:0] a, b;
    op_tab = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h03, 5'h10};
    prev_res = '0;

    // reset with a request already pending: nothing may be accepted while rst is high
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.dtype = 4'h1;
    bus.op    = 5'h01;
    bus.src1  = 16'hFFFF;
    bus.src2  = 16'h0001;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    check("rst_dz", bus.dz, 0);
    rst = 1'b0;
    @(posedge clk);
    collect("add_carry", 4'h1, 5'h01, 16'hFFFF, 16'h0001, 1'b0);
    check("add_carry_const", last_res, 32'h0001_0000);

    run("smul", 4'h2, 5'h04, 16'hFFFE, 16'h0003);
    check("smul_const", last_res, 32'hFFFF_FFFA);

    run("sdiv", 4'h2, 5'h08, 16'hFFF9, 16'h0002);
    if (DIV_EN) check("sdiv_const", last_res, 32'hFFFD_FFFF);
    else        check("div_off_err", last_err, 1);
    run("div0", 4'h2, 5'h08, 16'h0064, 16'h0000);
    if (DIV_EN) begin
      check("div0_const", last_res, 32'hFFFF_0064);
      check("div0_dz", last_dz, 1);
    end else begin
      check("div_off_dz", last_dz, 0);
    end
    run("sdiv_min", 4'h2, 5'h08, 16'h8000, 16'hFFFF);
    run("usub_neg", 4'h1, 5'h02, 16'h0001, 16'h0003);
    run("ssub", 4'h2, 5'h02, 16'h8000, 16'h0001);

    run("bad_op", 4'h1, 5'h03, 16'h1234, 16'h5678);
    check("bad_op_err_const", last_err, 1);
    run("bad_dt", 4'h3, 5'h01, 16'h1234, 16'h5678);

    // start held high for the whole multiply: exactly one done
    issue(4'h1, 5'h04, 16'h1234, 16'h00FF);
    collect("mul_hold", 4'h1, 5'h04, 16'h1234, 16'h00FF, 1'b1);
    extra = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("mul_hold_extra_done", extra, 0);

    // reset in ITER cycle 5 of a multiply: discarded, no done
    issue(4'h2, 5'h04, 16'h7FFF, 16'h8001);
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_res = '0;
    extra = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("midrst_no_done", extra, 0);
    run("add_after_rst", 4'h2, 5'h01, 16'h7FFF, 16'h0001);

    run("div_op", 4'h1, 5'h08, 16'h0064, 16'h0007);

    // randomized back-to-back traffic
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       dt = 4'($urandom);
        1, 2, 3, 4: dt = 4'h1;
        default: dt = 4'h2;
      endcase
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 5)];
      a  = pick_operand();
      b  = pick_operand();
      run($sformatf("rnd%0d", i), dt, op, a, b);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
